// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// One byte per grant; further grants are held off until tx_done or watchdog expiry.
module uart_tx_arbiter #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned NB_IDX         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned NB_TIMEOUT     = 18
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0]   i_req_data,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic                       i_tx_done,
    output logic                       o_tx_valid,
    output logic [NB_DATA-1:0]         o_tx_data,
    output logic [NB_IDX-1:0]          o_grant_idx,
    output logic                       o_busy,
    output logic                       o_timeout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [NB_IDX-1:0]     LAST_INIT = NB_IDX'(N_REQ - 1);
    localparam logic [NB_TIMEOUT-1:0] WD_LAST   = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q, state_d;
    logic [NB_IDX-1:0]     last_q;
    logic [NB_IDX-1:0]     grant_q;
    logic [NB_DATA-1:0]    data_q;
    logic [NB_TIMEOUT-1:0] wd_q, wd_d;

    logic                  found;
    logic [NB_IDX-1:0]     winner;
    logic                  accept;

    // Search starts one past the last grant so every active requester is reached
    // within N_REQ grants.
    always_comb begin
        int unsigned       cand;
        logic [NB_IDX-1:0] cand_idx;
        found  = 1'b0;
        winner = last_q;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand     = (32'(last_q) + i) % N_REQ;
            cand_idx = NB_IDX'(cand);
            if (!found && i_req_valid[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    assign accept = (state_q == IDLE) && found;

    always_comb begin
        o_req_ready = '0;
        if (accept) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        o_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
                wd_d    = '0;
            end
            WAIT: begin
                // A done pulse on the final watchdog cycle takes precedence over expiry.
                if (i_tx_done) begin
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    o_timeout = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + NB_TIMEOUT'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= LAST_INIT;
            grant_q <= '0;
            data_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (accept) begin
                last_q  <= winner;
                grant_q <= winner;
                data_q  <= i_req_data[32'(winner)*NB_DATA +: NB_DATA];
            end
        end
    end

    assign o_tx_valid  = (state_q == SEND);
    assign o_busy      = (state_q != IDLE);
    assign o_tx_data   = data_q;
    assign o_grant_idx = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus hand-written
// timeout, done-on-expiry, fairness and async-reset sequences.
module tb_uart_tx_arbiter;

    localparam int unsigned TO = 50;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [3:0]  i_req_valid = '0;
    logic [31:0] i_req_data = '0;
    logic [3:0]  o_req_ready;
    logic        i_tx_done = 1'b0;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic [1:0]  o_grant_idx;
    logic        o_busy;
    logic        o_timeout;

    uart_tx_arbiter #(
        .NB_DATA        (8),
        .N_REQ          (4),
        .NB_IDX         (2),
        .TIMEOUT_CYCLES (TO),
        .NB_TIMEOUT     (6)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .i_tx_done   (i_tx_done),
        .o_tx_valid  (o_tx_valid),
        .o_tx_data   (o_tx_data),
        .o_grant_idx (o_grant_idx),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_idx;
    } vec_t;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] idx, input logic [7:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        q.push_back(e);
    endtask

    // Scoreboard: each transmit strobe must match the oldest expected grant.
    always @(negedge i_clk) begin
        if (!i_reset && o_tx_valid) begin
            if (q.size() == 0) begin
                check("unexpected_tx_valid", 32'(o_tx_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_tx_data", 32'(o_tx_data), 32'(e.data));
                check("sb_grant_idx", 32'(o_grant_idx), 32'(e.idx));
            end
        end
    end

    task automatic do_reset();
        i_reset = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'b0100, 32'h11A52233, 4'b0100, 2'd2};
        vecs[1] = '{4'b1111, 32'h44332211, 4'b1000, 2'd3};
        vecs[2] = '{4'b1111, 32'h88776655, 4'b0001, 2'd0};
        vecs[3] = '{4'b0001, 32'h0000009C, 4'b0001, 2'd0};
        vecs[4] = '{4'b1010, 32'hDE00AD00, 4'b0010, 2'd1};
        vecs[5] = '{4'b1010, 32'hBE00EF00, 4'b1000, 2'd3};
        vecs[6] = '{4'b0110, 32'h00C3E100, 4'b0010, 2'd1};
        vecs[7] = '{4'b0000, 32'hFFFFFFFF, 4'b0000, 2'd0};
        vecs[8] = '{4'b1001, 32'h7F00005A, 4'b1000, 2'd3};
        vecs[9] = '{4'b1100, 32'h0F3C0000, 4'b0100, 2'd2};

        // Reset state and idle behaviour, including ignored done pulses.
        do_reset();
        #1;
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_grant", 32'(o_grant_idx), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
            #1;
            check("idle_done_busy", 32'(o_busy), 32'd0);
            check("idle_done_txv", 32'(o_tx_valid), 32'd0);
        end

        // Vector table; the pointer carries from one row to the next.
        for (int v = 0; v < 10; v++) begin
            logic [7:0] exp_byte;
            @(negedge i_clk);
            i_req_valid = vecs[v].valid;
            i_req_data  = vecs[v].data;
            exp_byte    = vecs[v].data[32'(vecs[v].exp_idx)*8 +: 8];
            #1;
            check("vec_ready", 32'(o_req_ready), 32'(vecs[v].exp_ready));
            if (vecs[v].exp_ready != 4'b0000) begin
                push(vecs[v].exp_idx, exp_byte);
                @(negedge i_clk);
                i_req_valid = '0;
                check("vec_tx_valid", 32'(o_tx_valid), 32'd1);
                repeat (3) @(negedge i_clk);
                check("vec_wait_busy", 32'(o_busy), 32'd1);
                check("vec_wait_ready", 32'(o_req_ready), 32'd0);
                i_tx_done = 1'b1;
                @(negedge i_clk);
                i_tx_done = 1'b0;
                #1;
                check("vec_idle_busy", 32'(o_busy), 32'd0);
                check("vec_hold_data", 32'(o_tx_data), 32'(exp_byte));
            end else begin
                @(negedge i_clk);
                check("vec_none_busy", 32'(o_busy), 32'd0);
                i_req_valid = '0;
            end
        end
        check("vec_queue_empty", 32'(q.size()), 32'd0);

        // Fairness: all requesters continuously valid.
        do_reset();
        i_req_valid = 4'b1111;
        i_req_data  = 32'h13121110;
        for (int f = 0; f < 6; f++) begin
            #1;
            check("rr_ready", 32'(o_req_ready), 32'(4'b0001 << (f % 4)));
            push(2'(f % 4), 8'h10 + 8'(f % 4));
            @(negedge i_clk);
            check("rr_tx_valid", 32'(o_tx_valid), 32'd1);
            repeat (2) begin
                @(negedge i_clk);
                check("rr_no_grant_busy", 32'(o_req_ready), 32'd0);
                check("rr_single_strobe", 32'(o_tx_valid), 32'd0);
            end
            i_tx_done = 1'b1;
            @(negedge i_clk);
            i_tx_done = 1'b0;
        end
        i_req_valid = '0;
        @(negedge i_clk);

        // Watchdog expiry with req 2 pending behind req 1.
        do_reset();
        i_req_valid = 4'b0110;
        i_req_data  = 32'h00C0B000;
        #1;
        check("to_ready", 32'(o_req_ready), 32'b0010);
        push(2'd1, 8'hB0);
        begin
            int cnt;
            @(negedge i_clk);
            i_req_valid = 4'b0100;
            cnt = 0;
            do begin
                @(negedge i_clk);
                cnt++;
                if (!o_timeout && cnt < 100) begin
                    if (o_req_ready != 4'b0000) check("to_ready_in_wait", 32'(o_req_ready), 32'd0);
                end
            end while (!o_timeout && cnt < 100);
            check("to_latency", 32'(cnt), 32'(TO));
        end
        @(negedge i_clk);
        #1;
        check("to_pulse_width", 32'(o_timeout), 32'd0);
        check("to_idle_busy", 32'(o_busy), 32'd0);
        check("to_next_ready", 32'(o_req_ready), 32'b0100);
        push(2'd2, 8'hC0);

        // Done on the watchdog's final cycle: no timeout pulse.
        @(negedge i_clk);
        i_req_valid = '0;
        check("de_tx_valid", 32'(o_tx_valid), 32'd1);
        repeat (TO) @(negedge i_clk);
        i_tx_done = 1'b1;
        #1;
        check("de_no_timeout", 32'(o_timeout), 32'd0);
        check("de_busy", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        i_tx_done = 1'b0;
        #1;
        check("de_idle_busy", 32'(o_busy), 32'd0);
        check("de_idle_timeout", 32'(o_timeout), 32'd0);
        check("de_hold_data", 32'(o_tx_data), 32'hC0);

        // Asynchronous reset mid-WAIT aborts the frame and resets the pointer.
        @(negedge i_clk);
        i_req_valid = 4'b1000;
        i_req_data  = 32'h77000000;
        #1;
        check("ar_ready", 32'(o_req_ready), 32'b1000);
        push(2'd3, 8'h77);
        @(negedge i_clk);
        i_req_valid = '0;
        repeat (3) @(negedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check("ar_busy", 32'(o_busy), 32'd0);
        check("ar_tx_valid", 32'(o_tx_valid), 32'd0);
        check("ar_tx_data", 32'(o_tx_data), 32'd0);
        check("ar_grant", 32'(o_grant_idx), 32'd0);
        check("ar_timeout", 32'(o_timeout), 32'd0);
        @(negedge i_clk);
        i_reset     = 1'b0;
        i_req_valid = 4'b1001;
        i_req_data  = 32'h5500003A;
        #1;
        check("ar_ptr_reset", 32'(o_req_ready), 32'b0001);
        push(2'd0, 8'h3A);
        @(negedge i_clk);
        i_req_valid = '0;
        check("ar_tx_valid2", 32'(o_tx_valid), 32'd1);
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        #1;
        check("ar_end_busy", 32'(o_busy), 32'd0);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL time_limit: got timeout, expected completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
